// File: rtl/if_pkg.sv
// Shared types and constants for the miniRV instruction-fetch stage.
// IF_FETCH_MISALIGN_CHK_EN adds the sticky FAULT state for misaligned redirects.
package if_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] INS_BUBBLE   = 32'h0000_0000;
    localparam int          PC_STEP      = 4;

`ifdef IF_FETCH_MISALIGN_CHK_EN
    typedef enum logic [1:0] {REQ, WAIT, HOLD, FAULT} fetch_state_e;
`else
    typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_e;
`endif

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, issues one ROM read at a time, hands words to decode.
// Define IF_FETCH_MISALIGN_CHK_EN to add fetch_fault and trap misaligned redirect targets.
module if_fetch
    import if_pkg::*;
#(
    parameter int             XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ins_valid,
    output logic [XLEN-1:0] ins,
    output logic [XLEN-1:0] ins_pc,
    input  logic            ins_ready
`ifdef IF_FETCH_MISALIGN_CHK_EN
    ,
    output logic            fetch_fault
`endif
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(2'b11);
    localparam logic [XLEN-1:0] BUBBLE     = XLEN'(INS_BUBBLE);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic            kill;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ALIGN_MASK;
    assign imem_req     = (state == REQ) && !rst;
    assign imem_addr    = pc & ALIGN_MASK;

`ifdef IF_FETCH_MISALIGN_CHK_EN
    logic redirect_bad;
    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REQ;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            ins_valid <= 1'b0;
            ins       <= BUBBLE;
            ins_pc    <= '0;
`ifdef IF_FETCH_MISALIGN_CHK_EN
            fetch_fault <= 1'b0;
`endif
        end else begin
            case (state)
                REQ: begin
                    if (redirect_valid) pc <= redirect_tgt;
                    // A grant alongside a redirect means the old-pc read is already out.
                    if (imem_gnt) begin
                        state <= WAIT;
                        kill  <= redirect_valid;
                    end
                end
                WAIT: begin
                    if (redirect_valid) pc <= redirect_tgt;
                    if (imem_rvalid) begin
                        if (redirect_valid || kill) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else begin
                            ins       <= imem_rdata;
                            ins_pc    <= pc;
                            ins_valid <= 1'b1;
                            pc        <= pc + XLEN'(PC_STEP);
                            state     <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid) pc <= redirect_tgt;
                    if (redirect_valid || ins_ready) begin
                        ins_valid <= 1'b0;
                        ins       <= BUBBLE;
                        ins_pc    <= '0;
                        state     <= REQ;
                    end
                end
`ifdef IF_FETCH_MISALIGN_CHK_EN
                FAULT: ;
`endif
                default: state <= REQ;
            endcase
`ifdef IF_FETCH_MISALIGN_CHK_EN
            // Misaligned target overrides everything above; only reset leaves FAULT.
            if (redirect_bad && state != FAULT) begin
                state       <= FAULT;
                fetch_fault <= 1'b1;
                kill        <= 1'b0;
                ins_valid   <= 1'b0;
                ins         <= BUBBLE;
                ins_pc      <= '0;
            end
`endif
        end
    end

`ifndef SYNTHESIS
    stray_rvalid_a: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> !(state == REQ || state == HOLD));
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: ROM responder plus an in-order delivered-PC stream model.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int RW_NONE = 0, RW_NOW = 1, RW_GNT = 2, RW_RV = 3, RW_WAIT = 4, RW_HOLD = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid, ins_ready;
    logic [31:0] ins, ins_pc;
`ifdef IF_FETCH_MISALIGN_CHK_EN
    logic        fetch_fault;
`endif

    always #5 clk = ~clk;

    if_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc), .ins_ready(ins_ready)
`ifdef IF_FETCH_MISALIGN_CHK_EN
        , .fetch_fault(fetch_fault)
`endif
    );

    int n_chk = 0, n_err = 0;
    int cyc = 0, idle = 0, n_deliv = 0, last_gnt_cyc = 0, cnt = 0;
    int gnt_pct, lat_min, lat_max, rdy_pct, redir_pct, redir_when;
    logic [31:0] force_tgt, exp_pc, prev_ins, prev_pc, pend_addr;
    logic [31:0] h_ins, h_pc;
    bit prev_valid, expect_bubble, busy, seen_new;
    logic [31:0] gnt_addrs[$];

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_1357;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: observe at negedge, check against the stream model, then drive the next inputs.
    task automatic step();
        bit do_r, cond, wait_cond;
        logic [31:0] tgt;
        @(negedge clk);
        cyc++;
        seen_new = 0;
        if (!ins_valid) begin
            chk("bubble_ins", ins, 32'h0);
            chk("bubble_pc", ins_pc, 32'h0);
        end else begin
            chk("ins_data", ins, rom(ins_pc));
            chk("hold_noreq", {31'b0, imem_req}, 32'h0);
            if (prev_valid) begin
                chk("ins_stable", ins, prev_ins);
                chk("pc_stable", ins_pc, prev_pc);
            end else begin
                chk("ins_pc_seq", ins_pc, exp_pc);
                seen_new = 1;
                n_deliv++;
            end
        end
        if (expect_bubble) chk("bubble_after", {31'b0, ins_valid}, 32'h0);
        if (imem_req) chk("req_addr", imem_addr, exp_pc);

        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (busy) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = rom(pend_addr);
                busy        = 0;
            end
        end
        wait_cond = busy;
        imem_gnt  = 1'b0;
        if (imem_req && !busy && int'($urandom % 100) < gnt_pct) begin
            imem_gnt     = 1'b1;
            busy         = 1;
            cnt          = lat_min + int'($urandom % (lat_max - lat_min + 1));
            pend_addr    = imem_addr;
            last_gnt_cyc = cyc;
            gnt_addrs.push_back(imem_addr);
        end
        ins_ready = int'($urandom % 100) < rdy_pct;

        tgt = $urandom & 32'h0000_0FFF;
`ifdef IF_FETCH_MISALIGN_CHK_EN
        tgt[1:0] = 2'b00;
`endif
        do_r = int'($urandom % 100) < redir_pct;
        case (redir_when)
            RW_NOW:  cond = 1;
            RW_GNT:  cond = imem_gnt;
            RW_RV:   cond = imem_rvalid;
            RW_WAIT: cond = wait_cond;
            RW_HOLD: cond = ins_valid;
            default: cond = 0;
        endcase
        if (cond) begin
            do_r       = 1;
            tgt        = force_tgt;
            redir_when = RW_NONE;
        end
        redirect_valid = do_r;
        redirect_pc    = tgt;

        expect_bubble = (ins_valid && ins_ready) || do_r;
        if (ins_valid && ins_ready) exp_pc = ins_pc + 32'd4;
        if (do_r) exp_pc = {tgt[31:2], 2'b00};
        prev_valid = ins_valid;
        prev_ins   = ins;
        prev_pc    = ins_pc;
        if (ins_valid || do_r) idle = 0; else idle++;
    endtask

    task automatic wait_new(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            step();
            if (seen_new) break;
        end
        chk(tag, {31'b0, seen_new}, 32'h1);
    endtask

    task automatic wait_gnt(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (gnt_addrs.size() > 0) break;
            step();
        end
        chk(tag, {31'b0, gnt_addrs.size() > 0}, 32'h1);
    endtask

    task automatic wait_fire(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (redir_when == RW_NONE) break;
            step();
        end
        chk(tag, redir_when, RW_NONE);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; ins_ready = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, ins_valid}, 32'h0);
        chk("rst_ins", ins, 32'h0);
        chk("rst_ins_pc", ins_pc, 32'h0);
`ifdef IF_FETCH_MISALIGN_CHK_EN
        chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        exp_pc = RST_PC; busy = 0; prev_valid = 0; expect_bubble = 0; idle = 0;
        redir_when = RW_NONE;
        gnt_addrs.delete();
    endtask

    task automatic directed_redirect(input string tag, input int when, input logic [31:0] tgt,
                                     input logic [31:0] want);
        redir_when = when;
        force_tgt  = tgt;
        wait_fire({tag, "_fire"}, 40);
        gnt_addrs.delete();
        wait_new({tag, "_deliver"}, 40);
        chk({tag, "_ins_pc"}, ins_pc, want);
        if (gnt_addrs.size() > 0) chk({tag, "_addr"}, gnt_addrs[0], want);
        else chk({tag, "_addr_seen"}, 32'h0, 32'h1);
    endtask

    initial begin
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; ins_ready = 1'b0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; rdy_pct = 100; redir_pct = 0;
        redir_when = RW_NONE; force_tgt = '0;
        do_reset();

        // Zero-wait ROM, first fetch from reset PC
        step();
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, RST_PC);
        wait_new("first_deliver", 10);
        chk("first_latency", cyc - last_gnt_cyc, 32'd2);
        chk("first_ins", ins, 32'h0050_0093);
        chk("first_ins_pc", ins_pc, 32'h0);
        for (int i = 0; i < 10 && gnt_addrs.size() < 2; i++) step();
        if (gnt_addrs.size() >= 2) chk("second_addr", gnt_addrs[1], 32'h4);
        else chk("second_addr_seen", 32'h0, 32'h1);

        // Decode stalls for 5 cycles
        rdy_pct = 0;
        wait_new("stall_deliver", 20);
        h_ins = ins; h_pc = ins_pc;
        repeat (5) step();
        chk("stall_valid", {31'b0, ins_valid}, 32'h1);
        chk("stall_ins", ins, h_ins);
        chk("stall_pc", ins_pc, h_pc);
        chk("stall_noreq", {31'b0, imem_req}, 32'h0);
        rdy_pct = 100;
        gnt_addrs.delete();
        wait_gnt("stall_next_gnt", 20);
        if (gnt_addrs.size() > 0) chk("stall_next_addr", gnt_addrs[0], h_pc + 32'd4);

        // Redirects at each pipeline position
        lat_min = 3; lat_max = 3;
        directed_redirect("rd_wait", RW_WAIT, 32'h100, 32'h100);
        lat_min = 2; lat_max = 2;
        directed_redirect("rd_gnt", RW_GNT, 32'h200, 32'h200);
        directed_redirect("rd_rv", RW_RV, 32'h300, 32'h300);
        rdy_pct = 0;
        wait_new("hold_setup", 20);
        directed_redirect("rd_hold", RW_HOLD, 32'h40, 32'h40);
        rdy_pct = 100;
`ifndef IF_FETCH_MISALIGN_CHK_EN
        directed_redirect("rd_misalign", RW_NOW, 32'h1237, 32'h1234);
`endif
        // PC wraps at the top of the address space
        directed_redirect("rd_wrap", RW_NOW, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        gnt_addrs.delete();
        wait_gnt("wrap_gnt", 20);
        if (gnt_addrs.size() > 0) chk("wrap_addr", gnt_addrs[0], 32'h0);

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            if (k % 200 == 0) begin
                gnt_pct   = 30 + int'($urandom % 71);
                lat_min   = 1 + int'($urandom % 2);
                lat_max   = lat_min + int'($urandom % 3);
                rdy_pct   = 20 + int'($urandom % 81);
                redir_pct = int'($urandom % 16);
            end
            step();
            if (idle > 60) begin
                chk("liveness", idle, 0);
                break;
            end
        end
        chk("deliveries", {31'b0, n_deliv > 100}, 32'h1);
        redir_pct = 0;

`ifdef IF_FETCH_MISALIGN_CHK_EN
        gnt_pct = 0; rdy_pct = 100;
        repeat (8) step();
        redir_when = RW_NOW; force_tgt = 32'h102;
        step();
        step();
        chk("fault_set", {31'b0, fetch_fault}, 32'h1);
        chk("fault_noreq", {31'b0, imem_req}, 32'h0);
        gnt_pct = 100;
        repeat (3) step();
        chk("fault_sticky", {31'b0, fetch_fault}, 32'h1);
        chk("fault_noreq2", {31'b0, imem_req}, 32'h0);
        chk("fault_novalid", {31'b0, ins_valid}, 32'h0);
        gnt_pct = 0;
        do_reset();
        step();
        chk("fault_cleared", {31'b0, fetch_fault}, 32'h0);
        chk("fault_restart_req", {31'b0, imem_req}, 32'h1);
        chk("fault_restart_addr", imem_addr, RST_PC);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
